mux_sel_pipe: RTL and testbench

Parametrised, pipelined N-channel, W-bit strobed selector with a complementary output pair. It generalises the single-bit 8:1 strobed multiplexer with true/complement outputs. It adds per-transaction or locked select, valid/ready flow control, out-of-range detection and a two-stage registered tree. It sits in the datapath benchmark set as the sequential successor used for power-aware synthesis runs.

---
 rtl/mux_sel_pkg.sv | 33 +++
 rtl/mux_grp_sel.sv | 29 ++
 rtl/mux_sel_pipe.sv | 142 ++++++++++++++
 tb/tb_mux_sel_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// ============================================================================
// Module  : mux_sel_pkg
// Brief   : Shared width helpers for the pipelined strobed channel selector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux_sel_pkg;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Select width never collapses to zero so single-entry selectors still have a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    function automatic int n_groups(input int nch, input int grp);
        return (nch + grp - 1) / grp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_grp_sel.sv
// ============================================================================
// Module  : mux_grp_sel
// Brief   : Combinational N:1 W-bit selector; out-of-range select yields zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_grp_sel #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int SW = 2
) (
    input  logic [N*W-1:0] i_data,
    input  logic [SW-1:0]  i_sel,
    output logic [W-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel == SW'(i)) begin
                o_data = i_data[i*W +: W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_sel_pipe.sv
// ============================================================================
// Module  : mux_sel_pipe
// Brief   : Two-stage pipelined NCH:1 strobed selector with true/complement out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_sel_pipe
    import mux_sel_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int W        = 1,
    parameter int GRP      = 4,
    localparam int SELW    = sel_width(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NCH*W-1:0] in_data,
    input  logic [SELW-1:0] in_sel,
    input  logic            in_strobe_n,
    input  logic            cfg_lock,
    input  logic            cfg_sel_we,
    input  logic [SELW-1:0] cfg_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [W-1:0]    out_data_n,
    output logic            out_err
);

    localparam int c_NGRP  = n_groups(NCH, GRP);
    localparam int c_GSW   = sel_width(GRP);
    localparam int c_GSELW = sel_width(c_NGRP);
    localparam int c_PADW  = c_NGRP * GRP * W;

    // Payload width depends on instance parameters, so the struct lives here.
    typedef struct packed {
        logic [c_NGRP-1:0][W-1:0] cand;
        logic [c_GSELW-1:0]       grp_sel;
        logic                     strobe_n;
        logic                     err;
    } s1_t;

    logic [SELW-1:0]          r_sel_reg;
    logic                     r_s1_v;
    s1_t                      r_s1;
    logic                     r_s2_v;
    logic [W-1:0]             r_out_data;
    logic                     r_out_err;

    logic                     w_s2_adv;
    logic                     w_s1_adv;
    logic                     w_acc;
    logic [SELW-1:0]          w_eff_sel;
    logic [31:0]              w_sel_ext;
    logic [c_GSW-1:0]         w_lo_sel;
    logic [c_PADW-1:0]        w_pad;
    logic [c_NGRP-1:0][W-1:0] w_cand;
    s1_t                      w_s1_next;
    logic [W-1:0]             w_s2_pick;

    assign w_s2_adv = ~r_s2_v | out_ready;
    assign w_s1_adv = ~r_s1_v | w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_acc    = in_valid & w_s1_adv;

    // sel_reg is read before its write lands, so a coincident write affects the next transaction.
    assign w_eff_sel = cfg_lock ? r_sel_reg : in_sel;
    assign w_sel_ext = 32'(w_eff_sel);
    assign w_lo_sel  = c_GSW'(w_sel_ext % 32'(GRP));
    assign w_pad     = c_PADW'(in_data);

    generate
        for (genvar g = 0; g < c_NGRP; g++) begin : g_grp
            mux_grp_sel #(
                .N  (GRP),
                .W  (W),
                .SW (c_GSW)
            ) u_grp_sel (
                .i_data (w_pad[g*GRP*W +: GRP*W]),
                .i_sel  (w_lo_sel),
                .o_data (w_cand[g])
            );
        end
    endgenerate

    always_comb begin
        w_s1_next          = '0;
        w_s1_next.cand     = w_cand;
        w_s1_next.grp_sel  = c_GSELW'(w_sel_ext / 32'(GRP));
        w_s1_next.strobe_n = in_strobe_n;
        w_s1_next.err      = (w_sel_ext >= 32'(NCH));
    end

    mux_grp_sel #(
        .N  (c_NGRP),
        .W  (W),
        .SW (c_GSELW)
    ) u_s2_sel (
        .i_data (r_s1.cand),
        .i_sel  (r_s1.grp_sel),
        .o_data (w_s2_pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_reg  <= '0;
            r_s1_v     <= 1'b0;
            r_s1       <= '0;
            r_s2_v     <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            if (cfg_sel_we) begin
                r_sel_reg <= cfg_sel;
            end
            if (w_s1_adv) begin
                r_s1_v <= w_acc;
                if (w_acc) begin
                    r_s1 <= w_s1_next;
                end
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_out_data <= (r_s1.strobe_n | r_s1.err) ? '0 : w_s2_pick;
                    r_out_err  <= r_s1.err;
                end
            end
        end
    end

    assign out_valid  = r_s2_v;
    assign out_data   = r_out_data;
    assign out_data_n = ~r_out_data;
    assign out_err    = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_pipe.sv
// ============================================================================
// Module  : tb_mux_sel_pipe
// Brief   : Directed self-checking bench for mux_sel_pipe (8x1 and 6x4 builds).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_sel_pipe;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Instance A: NCH=8, W=1
    logic       a_in_valid, a_in_ready, a_in_strobe_n, a_cfg_lock, a_cfg_sel_we;
    logic [7:0] a_in_data;
    logic [2:0] a_in_sel, a_cfg_sel;
    logic       a_out_valid, a_out_ready, a_out_data, a_out_data_n, a_out_err;

    // Instance B: NCH=6, W=4
    logic        b_in_valid, b_in_ready, b_in_strobe_n, b_cfg_lock, b_cfg_sel_we;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_sel, b_cfg_sel;
    logic        b_out_valid, b_out_ready, b_out_err;
    logic [3:0]  b_out_data, b_out_data_n;

    mux_sel_pipe #(.NCH(8), .W(1), .GRP(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_sel(a_in_sel), .in_strobe_n(a_in_strobe_n), .cfg_lock(a_cfg_lock),
        .cfg_sel_we(a_cfg_sel_we), .cfg_sel(a_cfg_sel), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_data_n(a_out_data_n),
        .out_err(a_out_err)
    );

    mux_sel_pipe #(.NCH(6), .W(4), .GRP(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_strobe_n(b_in_strobe_n), .cfg_lock(b_cfg_lock),
        .cfg_sel_we(b_cfg_sel_we), .cfg_sel(b_cfg_sel), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_data_n(b_out_data_n),
        .out_err(b_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_out_data !== 1'b0) begin errors++; $display("FAIL reset_a_data: got %b expected 0", a_out_data); end
        checks++; if (a_out_data_n !== 1'b1) begin errors++; $display("FAIL reset_a_data_n: got %b expected 1", a_out_data_n); end
        checks++; if (a_out_err !== 1'b0) begin errors++; $display("FAIL reset_a_err: got %b expected 0", a_out_err); end
        checks++; if (b_out_data_n !== 4'hF) begin errors++; $display("FAIL reset_b_data_n: got %h expected f", b_out_data_n); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    endtask

    task automatic test_basic_select();
        bit exp_bits [8];
        exp_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        a_in_data     = 8'b1010_0110;
        a_in_strobe_n = 1'b0;
        a_out_ready   = 1'b1;
        for (int c = 0; c < 9; c++) begin
            a_in_valid = (c < 8);
            a_in_sel   = 3'(c % 8);
            tick();
            if (c == 0) begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency: got valid %b expected 0", a_out_valid); end
            end else begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== exp_bits[c-1] || a_out_data_n !== ~exp_bits[c-1]) begin
                    errors++;
                    $display("FAIL basic_sel%0d: got valid %b data %b data_n %b expected 1 %b %b",
                             c - 1, a_out_valid, a_out_data, a_out_data_n, exp_bits[c-1], ~exp_bits[c-1]);
                end
            end
        end
        flush();
    endtask

    task automatic test_strobe();
        a_in_data     = 8'b0000_0010;
        a_in_sel      = 3'd1;
        a_in_strobe_n = 1'b1;
        a_in_valid    = 1'b1;
        tick();
        a_in_valid    = 1'b0;
        a_in_strobe_n = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 1'b0 || a_out_data_n !== 1'b1 || a_out_err !== 1'b0) begin
            errors++;
            $display("FAIL strobe: got v%b d%b dn%b e%b expected v1 d0 dn1 e0", a_out_valid, a_out_data, a_out_data_n, a_out_err);
        end
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 1'b1) begin
            errors++;
            $display("FAIL strobe_off: got v%b d%b expected v1 d1", a_out_valid, a_out_data);
        end
        flush();
    endtask

    task automatic test_lock();
        a_cfg_lock   = 1'b1;
        a_cfg_sel_we = 1'b1;
        a_cfg_sel    = 3'd5;
        a_in_sel     = 3'd2;
        a_in_valid   = 1'b1;
        a_in_data    = 8'h01;
        tick();
        a_cfg_sel_we = 1'b0;
        a_in_data    = 8'h20;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 1'b1) begin errors++; $display("FAIL lock_old_sel: got v%b d%b expected v1 d1", a_out_valid, a_out_data); end
        a_in_data = 8'h04;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 1'b1) begin errors++; $display("FAIL lock_new_sel: got v%b d%b expected v1 d1", a_out_valid, a_out_data); end
        a_in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 1'b0 || a_out_err !== 1'b0) begin errors++; $display("FAIL lock_ignore_in_sel: got v%b d%b e%b expected v1 d0 e0", a_out_valid, a_out_data, a_out_err); end
        a_cfg_lock = 1'b0;
        flush();
    endtask

    task automatic test_range();
        logic [2:0] sels [5];
        logic [3:0] exp_d [5];
        logic       exp_e [5];
        sels  = '{3'd7, 3'd5, 3'd4, 3'd6, 3'd0};
        exp_d = '{4'h0, 4'hA, 4'h5, 4'h0, 4'h1};
        exp_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        b_in_data     = 24'hA54321;
        b_in_strobe_n = 1'b0;
        b_out_ready   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            b_in_valid = (c < 5);
            if (c < 5) b_in_sel = sels[c];
            tick();
            if (c >= 1) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== exp_d[c-1] || b_out_data_n !== ~exp_d[c-1] || b_out_err !== exp_e[c-1]) begin
                    errors++;
                    $display("FAIL range_sel%0d: got v%b d%h dn%h e%b expected v1 d%h dn%h e%b",
                             sels[c-1], b_out_valid, b_out_data, b_out_data_n, b_out_err, exp_d[c-1], ~exp_d[c-1], exp_e[c-1]);
                end
            end
        end
        flush();
    endtask

    task automatic test_backpressure();
        logic [2:0] sels [6];
        logic [3:0] exp_d [6];
        logic [3:0] got [$];
        int idx;
        sels  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        exp_d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA};
        idx   = 0;
        b_in_data   = 24'hA54321;
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_sel    = sels[0];
        for (int c = 0; c < 5; c++) begin
            if (b_in_ready) idx++;
            tick();
            b_in_sel = sels[idx];
            if (c >= 1) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== 4'h1) begin
                    errors++;
                    $display("FAIL stall_hold: got v%b d%h expected v1 d1", b_out_valid, b_out_data);
                end
            end
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL stall_accepted: got %0d expected 2", idx); end
        checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", b_in_ready); end
        b_out_ready = 1'b1;
        #1;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL no_bubble_ready: got %b expected 1", b_in_ready); end
        for (int c = 0; c < 20 && got.size() < 6; c++) begin
            if (b_out_valid) got.push_back(b_out_data);
            if (b_in_valid && b_in_ready) idx++;
            tick();
            if (idx >= 6) b_in_valid = 1'b0;
            else          b_in_sel   = sels[idx];
        end
        checks++; if (got.size() != 6) begin errors++; $display("FAIL drain_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_d[i]) begin errors++; $display("FAIL drain_order%0d: got %h expected %h", i, got[i], exp_d[i]); end
        end
        flush();
    endtask

    task automatic test_reset_mid();
        a_in_data  = 8'hFF;
        a_in_sel   = 3'd0;
        a_in_valid = 1'b1;
        tick();
        tick();
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre: got %b expected 1", a_out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_out_data !== 1'b0) begin errors++; $display("FAIL midreset_async: got v%b d%b expected v0 d0", a_out_valid, a_out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_discard: got %b expected 0", a_out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_sel = '0; a_in_strobe_n = 1'b0;
        a_cfg_lock = 1'b0; a_cfg_sel_we = 1'b0; a_cfg_sel = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_sel = '0; b_in_strobe_n = 1'b0;
        b_cfg_lock = 1'b0; b_cfg_sel_we = 1'b0; b_cfg_sel = '0; b_out_ready = 1'b1;
        test_reset();
        test_basic_select();
        test_strobe();
        test_lock();
        test_range();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
